// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared widths, reset constants and a small helper for the 8-to-3 priority
// encoder slice.
//   DIN_W      : width of the request vector
//   DOUT_W     : width of the encoded index ($clog2(DIN_W))
//   Y_RST, VALID_RST, MULTI_RST : values the output register takes in reset
// ---------------------------------------------------------------------------
package encoder_pkg;

    localparam int DIN_W  = 8;
    localparam int DOUT_W = $clog2(DIN_W);

    localparam logic [DOUT_W-1:0] Y_RST     = 3'd0;
    localparam logic              VALID_RST = 1'b0;
    localparam logic              MULTI_RST = 1'b0;

    // Clearing the lowest set bit leaves something behind only when two or
    // more bits were set, so this flags a multi-hot vector without a popcount.
    function automatic logic multi_hot(input logic [DIN_W-1:0] v);
        return (v & (v - DIN_W'(1))) != DIN_W'(0);
    endfunction

endpackage : encoder_pkg

// File: rtl/encoder_8x3_comb.sv
// ---------------------------------------------------------------------------
// encoder_8x3_comb
// Stateless core of the encoder: selects one asserted request bit and
// reports whether any / more than one bit is asserted.
//   MSB_PRIORITY : 1 = highest-numbered set bit wins, 0 = lowest wins
//   d_i          : request vector
//   y_o          : index of the selected bit (0 when nothing is set)
//   valid_o      : at least one bit of d_i set
//   multi_o      : two or more bits of d_i set
// ---------------------------------------------------------------------------
module encoder_8x3_comb
    import encoder_pkg::*;
#(
    parameter int MSB_PRIORITY = 1
) (
    input  logic [DIN_W-1:0]  d_i,
    output logic [DOUT_W-1:0] y_o,
    output logic              valid_o,
    output logic              multi_o
);

    // Priority select plus status flags; the scan direction decides which set
    // bit is seen last and therefore wins.
    always_comb begin
        y_o     = Y_RST;
        valid_o = |d_i;
        multi_o = multi_hot(d_i);
        if (MSB_PRIORITY != 0) begin
            for (int i = 0; i < DIN_W; i++) begin
                y_o = d_i[i] ? DOUT_W'(i) : y_o;
            end
        end else begin
            for (int i = DIN_W - 1; i >= 0; i--) begin
                y_o = d_i[i] ? DOUT_W'(i) : y_o;
            end
        end
    end

endmodule : encoder_8x3_comb

// File: rtl/encoder_8x3_df.sv
// ---------------------------------------------------------------------------
// encoder_8x3_df
// Registered 8-to-3 priority encoder with "any" and "multiple" status flags.
// One cycle of latency, one new request vector accepted every cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears all outputs immediately
//   d     : request vector, bit i requests index i
//   y     : registered index of the selected bit
//   valid : registered "at least one bit set" (tells bit 0 from no request)
//   multi : registered "two or more bits set"
// ---------------------------------------------------------------------------
module encoder_8x3_df
    import encoder_pkg::*;
#(
    parameter int MSB_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  d,
    output logic [DOUT_W-1:0] y,
    output logic              valid,
    output logic              multi
);

    logic [DOUT_W-1:0] y_d;
    logic              valid_d;
    logic              multi_d;

    logic [DOUT_W-1:0] y_q;
    logic              valid_q;
    logic              multi_q;

    encoder_8x3_comb #(
        .MSB_PRIORITY (MSB_PRIORITY)
    ) u_comb (
        .d_i     (d),
        .y_o     (y_d),
        .valid_o (valid_d),
        .multi_o (multi_d)
    );

    // Output register bank; reset forces the idle encoding straight away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= Y_RST;
            valid_q <= VALID_RST;
            multi_q <= MULTI_RST;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule : encoder_8x3_df

// File: tb/tb_encoder_8x3_df.sv
// Scoreboard bench for encoder_8x3_df: both priority modes run side by side.
module tb_encoder_8x3_df;

    typedef struct packed {
        logic [2:0] y_msb;
        logic [2:0] y_lsb;
        logic       valid;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] y_m, y_l;
    logic       valid_m, valid_l, multi_m, multi_l;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    encoder_8x3_df #(.MSB_PRIORITY(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .d(d), .y(y_m), .valid(valid_m), .multi(multi_m)
    );

    encoder_8x3_df #(.MSB_PRIORITY(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .d(d), .y(y_l), .valid(valid_l), .multi(multi_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_y_msb"},     32'(y_m),     32'd0);
        chk({tag, "_valid_msb"}, 32'(valid_m), 32'd0);
        chk({tag, "_multi_msb"}, 32'(multi_m), 32'd0);
        chk({tag, "_y_lsb"},     32'(y_l),     32'd0);
        chk({tag, "_valid_lsb"}, 32'(valid_l), 32'd0);
        chk({tag, "_multi_lsb"}, 32'(multi_l), 32'd0);
    endtask

    // Apply a vector away from the capture edge and log what should follow it.
    task automatic drive(input logic [7:0] dv, input logic [2:0] ym, input logic [2:0] yl,
                         input logic v, input logic m);
        @(negedge clk);
        d = dv;
        q.push_back('{y_msb: ym, y_lsb: yl, valid: v, multi: m});
    endtask

    // Monitor: one capture per rising edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("y_msb",     32'(y_m),     32'(e.y_msb));
            chk("y_lsb",     32'(y_l),     32'(e.y_lsb));
            chk("valid_msb", 32'(valid_m), 32'(e.valid));
            chk("valid_lsb", 32'(valid_l), 32'(e.valid));
            chk("multi_msb", 32'(multi_m), 32'(e.multi));
            chk("multi_lsb", 32'(multi_l), 32'(e.multi));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d     = 8'hFF;

        // Reset held with all requests asserted and the clock running.
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("in_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back('{y_msb: 3'd7, y_lsb: 3'd0, valid: 1'b1, multi: 1'b1});

        // Walking one-hot.
        drive(8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
        drive(8'h02, 3'd1, 3'd1, 1'b1, 1'b0);
        drive(8'h04, 3'd2, 3'd2, 1'b1, 1'b0);
        drive(8'h08, 3'd3, 3'd3, 1'b1, 1'b0);
        drive(8'h10, 3'd4, 3'd4, 1'b1, 1'b0);
        drive(8'h20, 3'd5, 3'd5, 1'b1, 1'b0);
        drive(8'h40, 3'd6, 3'd6, 1'b1, 1'b0);
        drive(8'h80, 3'd7, 3'd7, 1'b1, 1'b0);

        // Zero versus bit 0.
        drive(8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        drive(8'h01, 3'd0, 3'd0, 1'b1, 1'b0);

        // Multi-hot priority.
        drive(8'b0101_0010, 3'd6, 3'd1, 1'b1, 1'b1);
        drive(8'h81,        3'd7, 3'd0, 1'b1, 1'b1);
        drive(8'h18,        3'd4, 3'd3, 1'b1, 1'b1);
        drive(8'h06,        3'd2, 3'd1, 1'b1, 1'b1);
        drive(8'hFF,        3'd7, 3'd0, 1'b1, 1'b1);
        drive(8'h00,        3'd0, 3'd0, 1'b0, 1'b0);

        // Mid-cycle change of d must not reach the outputs before the next edge.
        drive(8'h04, 3'd2, 3'd2, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        d = 8'h20;
        q.push_back('{y_msb: 3'd5, y_lsb: 3'd5, valid: 1'b1, multi: 1'b0});
        #1;
        chk("hold_y_msb", 32'(y_m), 32'd2);
        chk("hold_y_lsb", 32'(y_l), 32'd2);

        // Asynchronous reset between edges, with y = 5 on the outputs.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("async_rst_hold");
        rst_n = 1'b1;

        // Normal operation resumes after release.
        drive(8'h30, 3'd5, 3'd4, 1'b1, 1'b1);
        drive(8'h40, 3'd6, 3'd6, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_encoder_8x3_df
